// File: rtl/psdsquare.sv
// Sequential unsigned squarer: one shift-add step per clock over NUMBITS/2 iterations.
// The result register sq is loaded from the accumulator only on a stop pulse.
module psdsquare #(
  parameter int unsigned NUMBITS = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic [NUMBITS/2-1:0]   xin,
  output logic [NUMBITS-1:0]     sq,
  output logic                   busy
);

  localparam int unsigned Half = NUMBITS / 2;
  localparam int unsigned CntW = $clog2(Half) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Half - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  if ((NUMBITS % 2) != 0 || NUMBITS < 4) begin : gen_param_check
    $error("psdsquare: NUMBITS must be even and at least 4");
  end

  logic [0:0]         state_q, state_d;
  logic [NUMBITS-1:0] mcand_q, mcand_d;
  logic [Half-1:0]    mplr_q, mplr_d;
  logic [NUMBITS-1:0] acc_q, acc_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [NUMBITS-1:0] sq_q, sq_d;

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sq_d    = sq_q;

    // Stop captures the pre-edge accumulator, so it may coincide with a start.
    if (stop) begin
      sq_d = acc_q;
    end

    if (start) begin
      mcand_d = {{Half{1'b0}}, xin};
      mplr_d  = xin;
      acc_d   = '0;
      cnt_d   = '0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      if (mplr_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d = mcand_q << 1;
      mplr_d  = mplr_q >> 1;
      cnt_d   = cnt_q + CntW'(1);
      if (cnt_q == LastCnt) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sq_q    <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sq_q    <= sq_d;
    end
  end

  assign sq   = sq_q;
  assign busy = (state_q == RUN);

endmodule

// File: tb/tb_psdsquare.sv
// Self-checking bench for psdsquare (NUMBITS=32): vector table, corner sequences and a
// random regression, with stop results checked through an expected-value queue.
module tb_psdsquare;

  logic        clock;
  logic        reset;
  logic        start;
  logic        stop;
  logic [15:0] xin;
  logic [31:0] sq;
  logic        busy;

  psdsquare #(.NUMBITS(32)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .stop  (stop),
    .xin   (xin),
    .sq    (sq),
    .busy  (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] x;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [6];
  logic [31:0] sb [$];
  int          checks;
  int          failures;

  // Reference: after s steps the accumulator holds x * (x mod 2^s).
  logic [15:0] m_x;
  int          m_steps;
  bit          m_run;
  logic [31:0] m_sq;

  function automatic logic [31:0] model_acc();
    logic [15:0] mask;
    mask = (m_steps >= 16) ? 16'hFFFF : 16'((32'd1 << m_steps) - 32'd1);
    return {16'h0, m_x} * {16'h0, (m_x & mask)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_x     = '0;
    m_steps = 0;
    m_run   = 1'b0;
    m_sq    = '0;
    sb.delete();
  endtask

  // One clock: drive at negedge, sample 1 time unit after the rising edge.
  task automatic cycle(input bit s, input bit p, input logic [15:0] x);
    logic [31:0] exp;
    @(negedge clock);
    start = s;
    stop  = p;
    xin   = s ? x : 16'($urandom);
    if (p) sb.push_back(model_acc());
    if (s) begin
      m_x     = x;
      m_steps = 0;
      m_run   = 1'b1;
    end else if (m_run) begin
      m_steps++;
      if (m_steps == 16) m_run = 1'b0;
    end
    @(posedge clock);
    #1;
    check("busy", {31'h0, busy}, {31'h0, m_run});
    if (p) begin
      exp  = sb.pop_front();
      m_sq = exp;
      check("sq_stop", sq, exp);
    end else begin
      check("sq_hold", sq, m_sq);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    int w;
    logic [15:0] rx;
    checks   = 0;
    failures = 0;
    vecs[0] = '{x: 16'h0000, exp: 32'h0000_0000};
    vecs[1] = '{x: 16'h0003, exp: 32'h0000_0009};
    vecs[2] = '{x: 16'h1234, exp: 32'h014B_5A90};
    vecs[3] = '{x: 16'hFFFF, exp: 32'hFFFE_0001};
    vecs[4] = '{x: 16'h00FF, exp: 32'h0000_FE01};
    vecs[5] = '{x: 16'h8000, exp: 32'h4000_0000};

    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    xin   = '0;
    model_reset();
    #12;
    check("reset_sq", sq, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    // Table: start, 16 running cycles, stop at k+17, then verify hold.
    foreach (vecs[i]) begin
      cycle(1'b1, 1'b0, vecs[i].x);
      idle(16);
      cycle(1'b0, 1'b1, 16'h0);
      check("table_sq", sq, vecs[i].exp);
      idle(3);
    end

    // Restart five cycles after the first start.
    cycle(1'b1, 1'b0, 16'h00FF);
    idle(4);
    cycle(1'b1, 1'b0, 16'h0100);
    idle(16);
    cycle(1'b0, 1'b1, 16'h0);
    check("restart_sq", sq, 32'h0001_0000);

    // Simultaneous start and stop.
    cycle(1'b1, 1'b0, 16'd7);
    idle(16);
    cycle(1'b1, 1'b1, 16'd9);
    check("simul_old", sq, 32'h0000_0031);
    idle(16);
    cycle(1'b0, 1'b1, 16'h0);
    check("simul_new", sq, 32'h0000_0051);

    // Stop mid-run captures partial acc without disturbing the run.
    cycle(1'b1, 1'b0, 16'hBEEF);
    idle(5);
    cycle(1'b0, 1'b1, 16'h0);
    idle(10);
    cycle(1'b0, 1'b1, 16'h0);
    check("midstop_final", sq, 32'hBEEF * 32'hBEEF);

    // Asynchronous reset mid-operation; start/stop held high are ignored.
    cycle(1'b1, 1'b0, 16'hABCD);
    idle(7);
    cycle(1'b0, 1'b1, 16'h0);
    @(negedge clock);
    start = 1'b0;
    stop  = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("areset_sq", sq, 32'h0);
    check("areset_busy", {31'h0, busy}, 32'h0);
    start = 1'b1;
    stop  = 1'b1;
    @(posedge clock);
    #1;
    check("reset_ign_busy", {31'h0, busy}, 32'h0);
    check("reset_ign_sq", sq, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    model_reset();
    cycle(1'b0, 1'b1, 16'h0);
    check("post_reset_acc", sq, 32'h0);
    cycle(1'b1, 1'b0, 16'h0042);
    idle(16);
    cycle(1'b0, 1'b1, 16'h0);
    check("post_reset_sq", sq, 32'h0000_1104);

    // Random regression, including early stops.
    for (int n = 0; n < 1000; n++) begin
      rx = 16'($urandom);
      w  = int'($urandom_range(0, 20));
      cycle(1'b1, 1'b0, rx);
      idle(w);
      cycle(1'b0, 1'b1, 16'h0);
      if (w >= 16) check("rand_sq", sq, {16'h0, rx} * {16'h0, rx});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/psdsquare.md
PSDSQUARE -- requirements
Module: psdsquare

Interface
REQ-001 Parameter: NUMBITS, default 32, result width; operand width is NUMBITS/2; NUMBITS SHALL be even and at least 4.
REQ-002 Port: clock  input  1  master clock, rising edge.
REQ-003 Port: reset  input  1  asynchronous reset, active high.
REQ-004 Port: start  input  1  one-cycle pulse; begin a new square of xin.
REQ-005 Port: stop  input  1  one-cycle pulse; load output register sq from the accumulator.
REQ-006 Port: xin  input  NUMBITS/2  operand, unsigned integer.
REQ-007 Port: sq  output  NUMBITS  registered result, xin*xin, unsigned integer.
REQ-008 Port: busy  output  1  registered; high while iterations are in progress.

Function
REQ-009 Datapath registers SHALL be: mcand (NUMBITS, multiplicand), mplr (NUMBITS/2, multiplier), acc (NUMBITS, accumulator), cnt (iteration counter, ceil(log2(NUMBITS/2))+1 bits).
REQ-010 FSM states SHALL be IDLE and RUN; the FSM SHALL be in IDLE after reset.
REQ-011 Start sampled high at edge k SHALL load mcand={zeros,xin}, mplr=xin, acc=0 and cnt=0; the FSM SHALL enter RUN and busy SHALL be 1 after edge k.
REQ-012 Each edge in RUN SHALL perform one shift-add step: if mplr[0] then acc=acc+mcand; then mcand<<=1, mplr>>=1, cnt++.
REQ-013 Additions SHALL be modulo 2^NUMBITS; no overflow is possible for a full-width operand.
REQ-014 After the step at which cnt reaches NUMBITS/2 (edge k+NUMBITS/2), the FSM SHALL return to IDLE, busy SHALL be 0, and acc SHALL hold xin*xin exactly.
REQ-015 Latency: for NUMBITS=32, start at edge k gives a final acc at edge k+16, and stop sampled at edge k+17 or later gives the correct sq.
REQ-016 In IDLE, acc, mcand and mplr SHALL hold their values.
REQ-017 Stop sampled high at edge m SHALL load sq with the acc value present before edge m; sq SHALL hold its value at all other times.
REQ-018 Stop while busy=1 SHALL load the partial acc.
REQ-019 Stop while busy=1 SHALL NOT disturb the running iteration.
REQ-020 Start while busy=1 SHALL abort the current operation and restart per REQ-011 with the new xin.
REQ-021 Start and stop high at the same edge SHALL apply both: sq gets the old acc, and the new operation starts.
REQ-022 xin SHALL be sampled only at a start edge; changes to xin during RUN SHALL have no effect.

Reset
REQ-023 While reset=1, independent of clock, sq, acc, mcand, mplr and cnt SHALL be 0, busy SHALL be 0, and the FSM SHALL be in IDLE.
REQ-024 Reset asserted during RUN SHALL discard the operation; no step SHALL occur while reset=1.
REQ-025 Start and stop SHALL be ignored while reset=1.
REQ-026 The first start accepted after reset release SHALL behave per REQ-011.

Verification
REQ-027 Full-scale: xin=0xFFFF, start at edge k, stop at edge k+17 -> busy high for exactly 16 cycles, then sq=0xFFFE0001.
REQ-028 Zero and small values: xin=0 -> sq=0x00000000; xin=3 -> sq=0x00000009; xin=0x1234 -> sq=0x014B5A90; after each, sq holds until the next stop.
REQ-029 Restart: start with xin=0x00FF, then start with xin=0x0100 five cycles later, stop 17 cycles after the second start -> sq=0x00010000; busy never drops between the two starts.
REQ-030 Simultaneous: complete xin=7 (acc=49), then assert start (xin=9) and stop at the same edge -> sq=0x00000031 at once; a later stop gives sq=0x00000051.
REQ-031 Reset mid-operation: start xin=0xABCD, assert reset asynchronously at cycle 8 -> sq, busy and acc go to 0 immediately; a stop after release gives sq=0.
REQ-032 Random regression: at least 1000 random xin values with stop at or after k+17 -> sq equals xin*xin in every case; early stops give a partial acc that matches a reference shift-add model.
